// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer.
package alarm_pkg;

  localparam int unsigned HH_W  = 5;
  localparam int unsigned MM_W  = 6;
  localparam int unsigned SNZ_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

endpackage

// File: rtl/alarm_ctrl_if.sv
// Time/button inputs and buzzer/status outputs of alarm_ctrl.
interface alarm_ctrl_if;
  import alarm_pkg::*;

  logic             tick;
  logic [HH_W-1:0]  cur_hh;
  logic [MM_W-1:0]  cur_mm;
  logic [HH_W-1:0]  alm_hh;
  logic [MM_W-1:0]  alm_mm;
  logic             arm;
  logic             disarm;
  logic             stop_btn;
  logic             snooze_btn;
  logic [1:0]       state;
  logic             buzzer;
  logic [SNZ_W-1:0] snooze_left;

  modport master (
    output tick, cur_hh, cur_mm, alm_hh, alm_mm, arm, disarm, stop_btn, snooze_btn,
    input  state, buzzer, snooze_left
  );

  modport slave (
    input  tick, cur_hh, cur_mm, alm_hh, alm_mm, arm, disarm, stop_btn, snooze_btn,
    output state, buzzer, snooze_left
  );

endinterface

// File: rtl/alarm_ctrl_sec_down_counter.sv
// Seconds down-counter: load has priority, decrement never wraps below zero.
module sec_down_counter #(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arm/disarm, minute-match edge trigger, ring timeout, stop and snooze.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZES = 3,
  parameter int unsigned CNT_W       = 9
) (
  input  logic         clk,
  input  logic         reset,
  alarm_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SECS);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECS);

  state_t           state_q;
  logic             buzzer_q;
  logic             match_q;
  logic             match;
  logic             hit;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             last_sec;
  logic             busy;
  logic             stop_ev;
  logic             snz_ev;
  logic             exp_ev;
  logic             hit_ev;
  logic             cnt_ld;
  logic [CNT_W-1:0] cnt_ld_val;
  logic             cnt_dec;

  assign match = (bus.cur_hh == bus.alm_hh) && (bus.cur_mm == bus.alm_mm);
  assign hit   = match & ~match_q;

  // Expiry fires on the tick that takes the counter to zero, so N loaded seconds last N ticks.
  assign last_sec = cnt_zero | (cnt == CNT_W'(1));
  assign busy     = (state_q == ST_RINGING) || (state_q == ST_SNOOZE);

`ifdef ALARM_SNOOZE_EN
  localparam logic [SNZ_W-1:0] MAX_SNZ = SNZ_W'(MAX_SNOOZES);
  logic [SNZ_W-1:0] used_q;

  assign snz_ev = (state_q == ST_RINGING) & ~bus.disarm & ~bus.stop_btn &
                  bus.snooze_btn & (used_q < MAX_SNZ);
  assign bus.snooze_left = (used_q < MAX_SNZ) ? (MAX_SNZ - used_q) : '0;
`else
  logic unused_cfg;

  assign snz_ev          = 1'b0;
  assign bus.snooze_left = '0;
  assign unused_cfg      = bus.snooze_btn ^ (^SNZ_W'(MAX_SNOOZES));
`endif

  // Event decode in priority order: disarm > stop > snooze > expiry > hit.
  assign stop_ev = busy & ~bus.disarm & bus.stop_btn;
  assign exp_ev  = busy & ~bus.disarm & ~bus.stop_btn & ~snz_ev & bus.tick & last_sec;
  assign hit_ev  = (state_q == ST_ARMED) & ~bus.disarm & hit;

  assign cnt_ld     = hit_ev | snz_ev | (exp_ev & (state_q == ST_SNOOZE));
  assign cnt_ld_val = snz_ev ? SNOOZE_LD : RING_LD;
  assign cnt_dec    = bus.tick & busy & ~cnt_ld;

  sec_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .ld_i     (cnt_ld),
    .ld_val_i (cnt_ld_val),
    .dec_i    (cnt_dec),
    .cnt_o    (cnt),
    .zero_o   (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      buzzer_q <= 1'b0;
      match_q  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      used_q   <= '0;
`endif
    end else begin
      match_q <= match;
      if (bus.disarm) begin
        state_q  <= ST_IDLE;
        buzzer_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.arm) state_q <= ST_ARMED;
          end
          ST_ARMED: begin
            if (hit_ev) begin
              state_q  <= ST_RINGING;
              buzzer_q <= 1'b1;
`ifdef ALARM_SNOOZE_EN
              used_q   <= '0;
`endif
            end
          end
          ST_RINGING: begin
            if (stop_ev || exp_ev) begin
              state_q  <= ST_ARMED;
              buzzer_q <= 1'b0;
            end else if (snz_ev) begin
              state_q  <= ST_SNOOZE;
              buzzer_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
              used_q   <= used_q + SNZ_W'(1);
`endif
            end else if (bus.tick) begin
              buzzer_q <= ~buzzer_q;
            end
          end
          ST_SNOOZE: begin
            if (stop_ev) begin
              state_q  <= ST_ARMED;
              buzzer_q <= 1'b0;
            end else if (exp_ev) begin
              state_q  <= ST_RINGING;
              buzzer_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            buzzer_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state  = state_q;
  assign bus.buzzer = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl (RING=5, SNOOZE=3, MAX_SNOOZES=2, tick every 4 clks).
module tb_alarm_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alarm_ctrl_if bus ();

  alarm_ctrl #(
    .RING_SECS   (5),
    .SNOOZE_SECS (3),
    .MAX_SNOOZES (2),
    .CNT_W       (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One second: a single-cycle tick then three idle clocks.
  task automatic sec();
    bus.tick = 1'b1;
    clk1();
    bus.tick = 1'b0;
    repeat (3) clk1();
  endtask

  task automatic trigger();
    bus.cur_hh = 5'd7;
    bus.cur_mm = 6'd29;
    clk1();
    bus.cur_mm = 6'd30;
    clk1();
  endtask

  task automatic test_reset();
    logic [1:0] exp_left;
`ifdef ALARM_SNOOZE_EN
    exp_left = 2'd2;
`else
    exp_left = 2'd0;
`endif
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL reset_buzzer got=%0d exp=0", bus.buzzer); end
    checks++; if (bus.snooze_left !== exp_left) begin failures++; $display("FAIL reset_left got=%0d exp=%0d", bus.snooze_left, exp_left); end
  endtask

  task automatic test_arm();
    bus.arm = 1'b1; clk1(); bus.arm = 1'b0;
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL arm_state got=%0d exp=1", bus.state); end
    bus.arm = 1'b1; clk1(); bus.arm = 1'b0;
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL arm_again got=%0d exp=1", bus.state); end
  endtask

  task automatic test_ring_timeout();
    trigger();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL ring_state got=%0d exp=2", bus.state); end
    checks++; if (bus.buzzer !== 1'b1) begin failures++; $display("FAIL ring_buzzer got=%0d exp=1", bus.buzzer); end
    for (int i = 1; i <= 4; i++) begin
      sec();
      checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL ring_hold tick=%0d got=%0d exp=2", i, bus.state); end
      checks++; if (bus.buzzer !== ((i % 2) == 0)) begin failures++; $display("FAIL ring_toggle tick=%0d got=%0d exp=%0d", i, bus.buzzer, (i % 2) == 0); end
    end
    sec();
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL timeout_state got=%0d exp=1", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL timeout_buzzer got=%0d exp=0", bus.buzzer); end
    sec(); sec();
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL no_retrigger got=%0d exp=1", bus.state); end
  endtask

  task automatic test_async_reset();
    trigger();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL pre_reset_state got=%0d exp=2", bus.state); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL async_state got=%0d exp=0", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL async_buzzer got=%0d exp=0", bus.buzzer); end
    #2 reset = 1'b1;
    clk1();
    bus.arm = 1'b1; clk1(); bus.arm = 1'b0;
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL rearm_state got=%0d exp=1", bus.state); end
    clk1(); clk1();
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL rearm_no_hit got=%0d exp=1", bus.state); end
  endtask

  task automatic test_priority();
    trigger();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL prio_ring got=%0d exp=2", bus.state); end
    bus.disarm = 1'b1; bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
    clk1();
    bus.disarm = 1'b0; bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL prio_disarm got=%0d exp=0", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL prio_buzzer got=%0d exp=0", bus.buzzer); end
    bus.arm = 1'b1; clk1(); bus.arm = 1'b0;
    trigger();
    bus.alm_hh = 5'd8; bus.alm_mm = 6'd0;
    sec();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL almchg_state got=%0d exp=2", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL almchg_buzzer got=%0d exp=0", bus.buzzer); end
    bus.alm_hh = 5'd7; bus.alm_mm = 6'd30;
    bus.stop_btn = 1'b1; clk1(); bus.stop_btn = 1'b0;
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL stop_state got=%0d exp=1", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL stop_buzzer got=%0d exp=0", bus.buzzer); end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    trigger();
    checks++; if (bus.snooze_left !== 2'd2) begin failures++; $display("FAIL snz_left0 got=%0d exp=2", bus.snooze_left); end
    bus.snooze_btn = 1'b1; clk1(); bus.snooze_btn = 1'b0;
    checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL snz1_state got=%0d exp=3", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL snz1_buzzer got=%0d exp=0", bus.buzzer); end
    checks++; if (bus.snooze_left !== 2'd1) begin failures++; $display("FAIL snz1_left got=%0d exp=1", bus.snooze_left); end
    sec(); sec();
    checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL snz1_hold got=%0d exp=3", bus.state); end
    checks++; if (bus.buzzer !== 1'b0) begin failures++; $display("FAIL snz1_quiet got=%0d exp=0", bus.buzzer); end
    sec();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL rering1_state got=%0d exp=2", bus.state); end
    checks++; if (bus.buzzer !== 1'b1) begin failures++; $display("FAIL rering1_buzzer got=%0d exp=1", bus.buzzer); end
    bus.snooze_btn = 1'b1; clk1(); bus.snooze_btn = 1'b0;
    checks++; if (bus.state !== 2'd3) begin failures++; $display("FAIL snz2_state got=%0d exp=3", bus.state); end
    checks++; if (bus.snooze_left !== 2'd0) begin failures++; $display("FAIL snz2_left got=%0d exp=0", bus.snooze_left); end
    sec(); sec(); sec();
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL rering2_state got=%0d exp=2", bus.state); end
    bus.snooze_btn = 1'b1; clk1(); bus.snooze_btn = 1'b0;
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL snz3_ignored got=%0d exp=2", bus.state); end
    checks++; if (bus.buzzer !== 1'b1) begin failures++; $display("FAIL snz3_buzzer got=%0d exp=1", bus.buzzer); end
    checks++; if (bus.snooze_left !== 2'd0) begin failures++; $display("FAIL snz3_left got=%0d exp=0", bus.snooze_left); end
    bus.stop_btn = 1'b1; clk1(); bus.stop_btn = 1'b0;
    trigger();
    checks++; if (bus.snooze_left !== 2'd2) begin failures++; $display("FAIL new_event_left got=%0d exp=2", bus.snooze_left); end
    bus.snooze_btn = 1'b1; clk1(); bus.snooze_btn = 1'b0;
    bus.stop_btn = 1'b1; clk1(); bus.stop_btn = 1'b0;
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL snz_stop_state got=%0d exp=1", bus.state); end
  endtask
`else
  task automatic test_no_snooze();
    trigger();
    bus.snooze_btn = 1'b1; clk1(); bus.snooze_btn = 1'b0;
    checks++; if (bus.state !== 2'd2) begin failures++; $display("FAIL nosnz_state got=%0d exp=2", bus.state); end
    checks++; if (bus.buzzer !== 1'b1) begin failures++; $display("FAIL nosnz_buzzer got=%0d exp=1", bus.buzzer); end
    checks++; if (bus.snooze_left !== 2'd0) begin failures++; $display("FAIL nosnz_left got=%0d exp=0", bus.snooze_left); end
  endtask
`endif

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    bus.tick       = 1'b0;
    bus.cur_hh     = 5'd0;
    bus.cur_mm     = 6'd0;
    bus.alm_hh     = 5'd7;
    bus.alm_mm     = 6'd30;
    bus.arm        = 1'b0;
    bus.disarm     = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
    repeat (2) clk1();
    test_reset();
    reset = 1'b1;
    clk1();
    test_arm();
    test_ring_timeout();
    test_async_reset();
    test_priority();
`ifdef ALARM_SNOOZE_EN
    test_snooze();
`else
    test_no_snooze();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
